// File: rtl/canvas_pkg.sv
// ============================================================================
// Module : canvas_pkg
// Brief  : Shared sizes, state encoding and index types for the canvas buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package canvas_pkg;
    localparam int CANVAS_W      = 32;
    localparam int CANVAS_ADDR_W = 10;
    localparam int CANVAS_IDX_W  = $clog2(CANVAS_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STAMP = 2'd1,
        CLEAR = 2'd2
    } canvas_state_e;

    typedef logic [CANVAS_IDX_W-1:0] row_idx_t;
    typedef logic [CANVAS_IDX_W-1:0] col_idx_t;
endpackage

`default_nettype wire

// File: rtl/canvas_row_mask.sv
// ============================================================================
// Module : canvas_row_mask
// Brief  : Column mask centred on x; 3 wide with edge clipping when
//          CANVAS_BRUSH3_EN is defined, otherwise a single pixel.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module canvas_row_mask
    import canvas_pkg::*;
(
    input  logic [CANVAS_IDX_W-1:0] x_i,
    output logic [CANVAS_W-1:0]     mask_o
);
    logic [CANVAS_W-1:0] centre;

    assign centre = {{(CANVAS_W-1){1'b0}}, 1'b1} << x_i;

`ifdef CANVAS_BRUSH3_EN
    // Logical shifts drop bits past either edge, which gives clipping without wrap.
    assign mask_o = centre | (centre << 1) | (centre >> 1);
`else
    assign mask_o = centre;
`endif
endmodule

`default_nettype wire

// File: rtl/canvas_buffer.sv
// ============================================================================
// Module : canvas_buffer
// Brief  : 32x32 one-bit canvas with pen writes, sequential clear and two
//          read ports. Optional 3x3 brush via CANVAS_BRUSH3_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module canvas_buffer
    import canvas_pkg::*;
#(
    parameter int W = CANVAS_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pen_valid,
    output logic                   pen_ready,
    input  logic [$clog2(W)-1:0]   pen_x,
    input  logic [$clog2(W)-1:0]   pen_y,
    input  logic                   pen_ink,
    input  logic                   clear_req,
    input  logic                   lock,
    input  logic [2*$clog2(W)-1:0] read_addr,
    output logic                   read_data,
    input  logic [$clog2(W)-1:0]   disp_row,
    output logic [W-1:0]           disp_bits,
    output logic                   busy,
    output logic                   dirty
);
    localparam int IW = $clog2(W);

    logic [W-1:0]  rows_q [W];
    canvas_state_e state_q, state_d;
    logic          clear_pend_q, clear_pend_d;
    logic          dirty_q, dirty_d;
    row_idx_t      clr_row_q, clr_row_d;

    logic          wr_en;
    row_idx_t      wr_row;
    logic [W-1:0]  wr_mask;
    logic          wr_ink;
    logic [W-1:0]  pen_mask;
    col_idx_t      mask_x;

`ifdef CANVAS_BRUSH3_EN
    col_idx_t      stamp_x_q, stamp_x_d;
    row_idx_t      stamp_y_q, stamp_y_d;
    logic          stamp_ink_q, stamp_ink_d;
    logic [1:0]    stamp_r_q, stamp_r_d;
    logic [IW:0]   stamp_row;

    // One extra bit so y-1 below row 0 and y+1 past the last row both land out of range.
    assign stamp_row = {1'b0, stamp_y_q} + {{(IW-1){1'b0}}, stamp_r_q} - (IW+1)'(1);
    assign mask_x    = stamp_x_q;
`else
    assign mask_x    = pen_x;
`endif

    canvas_row_mask u_row_mask (
        .x_i    (mask_x),
        .mask_o (pen_mask)
    );

    assign read_data = rows_q[read_addr[2*IW-1:IW]][read_addr[IW-1:0]];
    assign disp_bits = rows_q[disp_row];
    assign busy      = (state_q != IDLE) | clear_pend_q;
    assign dirty     = dirty_q;

    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q | (clear_req & (state_q != CLEAR));
        dirty_d      = dirty_q;
        clr_row_d    = clr_row_q;
        pen_ready    = 1'b0;
        wr_en        = 1'b0;
        wr_row       = pen_y;
        wr_mask      = pen_mask;
        wr_ink       = pen_ink;
`ifdef CANVAS_BRUSH3_EN
        stamp_x_d    = stamp_x_q;
        stamp_y_d    = stamp_y_q;
        stamp_ink_d  = stamp_ink_q;
        stamp_r_d    = stamp_r_q;
`endif
        case (state_q)
            IDLE: begin
                pen_ready = ~lock & ~clear_pend_q;
                if (clear_pend_q & ~lock) begin
                    state_d      = CLEAR;
                    clr_row_d    = '0;
                    clear_pend_d = 1'b0;
                end else if (pen_valid & pen_ready) begin
                    if (pen_ink) begin
                        dirty_d = 1'b1;
                    end
`ifdef CANVAS_BRUSH3_EN
                    state_d     = STAMP;
                    stamp_x_d   = pen_x;
                    stamp_y_d   = pen_y;
                    stamp_ink_d = pen_ink;
                    stamp_r_d   = 2'd0;
`else
                    wr_en = 1'b1;
`endif
                end
            end
`ifdef CANVAS_BRUSH3_EN
            STAMP: begin
                wr_en     = ~stamp_row[IW];
                wr_row    = stamp_row[IW-1:0];
                wr_ink    = stamp_ink_q;
                stamp_r_d = stamp_r_q + 2'd1;
                if (stamp_r_q == 2'd2) begin
                    state_d = IDLE;
                end
            end
`endif
            CLEAR: begin
                wr_en     = 1'b1;
                wr_row    = clr_row_q;
                wr_mask   = '1;
                wr_ink    = 1'b0;
                clr_row_d = clr_row_q + 1'b1;
                if (clr_row_q == row_idx_t'(W-1)) begin
                    state_d = IDLE;
                    dirty_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            clear_pend_q <= 1'b0;
            dirty_q      <= 1'b0;
            clr_row_q    <= '0;
`ifdef CANVAS_BRUSH3_EN
            stamp_x_q    <= '0;
            stamp_y_q    <= '0;
            stamp_ink_q  <= 1'b0;
            stamp_r_q    <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            dirty_q      <= dirty_d;
            clr_row_q    <= clr_row_d;
`ifdef CANVAS_BRUSH3_EN
            stamp_x_q    <= stamp_x_d;
            stamp_y_q    <= stamp_y_d;
            stamp_ink_q  <= stamp_ink_d;
            stamp_r_q    <= stamp_r_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < W; i++) begin
                rows_q[i] <= '0;
            end
        end else if (wr_en) begin
            if (wr_ink) begin
                rows_q[wr_row] <= rows_q[wr_row] | wr_mask;
            end else begin
                rows_q[wr_row] <= rows_q[wr_row] & ~wr_mask;
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_canvas_buffer.sv
// ============================================================================
// Module : tb_canvas_buffer
// Brief  : Self-checking bench for canvas_buffer (either CANVAS_BRUSH3_EN build).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_canvas_buffer;
`ifdef CANVAS_BRUSH3_EN
    localparam bit BRUSH = 1'b1;
`else
    localparam bit BRUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pen_valid = 1'b0;
    logic        pen_ink = 1'b0;
    logic        clear_req = 1'b0;
    logic        lock = 1'b0;
    logic [4:0]  pen_x = 5'd0;
    logic [4:0]  pen_y = 5'd0;
    logic        pen_ready, read_data, busy, dirty;
    logic [9:0]  read_addr;
    logic [4:0]  disp_row;
    logic [31:0] disp_bits;

    logic        addr_hold = 1'b0;
    logic [9:0]  addr_sel = 10'd0;
    logic        disp_hold = 1'b0;
    logic [4:0]  disp_sel = 5'd0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    // Free-running read addresses exercise both ports whenever a test is not pinning them.
    assign read_addr = addr_hold ? addr_sel : 10'(cyc * 37);
    assign disp_row  = disp_hold ? disp_sel : 5'(cyc);

    canvas_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pen_valid (pen_valid),
        .pen_ready (pen_ready),
        .pen_x     (pen_x),
        .pen_y     (pen_y),
        .pen_ink   (pen_ink),
        .clear_req (clear_req),
        .lock      (lock),
        .read_addr (read_addr),
        .read_data (read_data),
        .disp_row  (disp_row),
        .disp_bits (disp_bits),
        .busy      (busy),
        .dirty     (dirty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m [32][32];
    bit m_pend, m_dirty;
    int m_clr;      // clear cycles still to run
    int m_stamp;    // stamp cycles still to run
    int sx, sy;
    bit sink;

    function automatic bit m_ready();
        return !lock && !m_pend && m_clr == 0 && m_stamp == 0;
    endfunction

    function automatic logic [31:0] m_row(input int r);
        logic [31:0] v;
        for (int c = 0; c < 32; c++) v[c] = m[r][c];
        return v;
    endfunction

    task automatic paint(input int r, input int c, input bit v);
        if (r >= 0 && r < 32 && c >= 0 && c < 32) m[r][c] = v;
    endtask

    always @(posedge clk or negedge rst_n) begin
        bit rdy, in_clear, entered;
        int r;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                for (int j = 0; j < 32; j++) m[i][j] = 1'b0;
            m_pend = 0; m_dirty = 0; m_clr = 0; m_stamp = 0;
        end else begin
            rdy      = m_ready();
            in_clear = (m_clr > 0);
            entered  = 1'b0;
            if (m_clr > 0) begin
                for (int c = 0; c < 32; c++) m[32 - m_clr][c] = 1'b0;
                m_clr--;
                if (m_clr == 0) m_dirty = 1'b0;
            end else if (m_stamp > 0) begin
                r = sy + 2 - m_stamp;
                for (int dx = -1; dx <= 1; dx++) paint(r, sx + dx, sink);
                m_stamp--;
            end else if (m_pend && !lock) begin
                m_clr   = 32;
                m_pend  = 1'b0;
                entered = 1'b1;
            end else if (pen_valid && rdy) begin
                if (BRUSH) begin
                    m_stamp = 3; sx = int'(pen_x); sy = int'(pen_y); sink = pen_ink;
                end else begin
                    paint(int'(pen_y), int'(pen_x), pen_ink);
                end
                if (pen_ink) m_dirty = 1'b1;
            end
            if (clear_req && !in_clear && !entered) m_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("read_data", 32'(read_data), 32'(m[read_addr[9:5]][read_addr[4:0]]));
        chk("disp_bits", disp_bits, m_row(int'(disp_row)));
        chk("busy", 32'(busy), 32'(m_pend || m_clr > 0 || m_stamp > 0));
        chk("dirty", 32'(dirty), 32'(m_dirty));
        chk("pen_ready", 32'(pen_ready), 32'(m_ready()));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pen(input int x, input int y, input bit ink);
        int n = 0;
        pen_x = 5'(x); pen_y = 5'(y); pen_ink = ink; pen_valid = 1'b1;
        while (!pen_ready && n < 100) begin tick(); n++; end
        chk("pen_accept_wait", 32'(n < 100), 32'd1);
        tick();
        pen_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin tick(); n++; end
        chk("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic count_ones(output int ones);
        ones = 0;
        addr_hold = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            addr_sel = 10'(i);
            #1;
            if (read_data !== 1'b0) ones++;
        end
    endtask

    initial begin
        int n, ones, bad;
        bit seen;
        logic exp_px;

        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dirty", 32'(dirty), 32'd0);
        disp_hold = 1'b1;
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            disp_sel = 5'(r); #1;
            if (disp_bits !== 32'd0) bad++;
        end
        chk("rst_rows_zero", bad, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(pen_ready), 32'd1);

        // single pixel at row 2, column 3 -> address 67
        pen(3, 2, 1'b1);
        wait_idle();
        addr_hold = 1'b1;
        addr_sel = 10'd67; #1;
        chk("px_67", 32'(read_data), 32'd1);
        chk("dirty_after_draw", 32'(dirty), 32'd1);
        if (!BRUSH) begin
            addr_sel = 10'd66; #1; chk("px_66", 32'(read_data), 32'd0);
            addr_sel = 10'd68; #1; chk("px_68", 32'(read_data), 32'd0);
            addr_sel = 10'd35; #1; chk("px_35", 32'(read_data), 32'd0);
            addr_sel = 10'd99; #1; chk("px_99", 32'(read_data), 32'd0);
        end
        addr_hold = 1'b0;

        // corner stroke at x=0, y=31
        pen_x = 5'd0; pen_y = 5'd31; pen_ink = 1'b1; pen_valid = 1'b1;
        tick();
        pen_valid = 1'b0;
        n = 0;
        while (!pen_ready && n < 10) begin n++; tick(); end
        chk("stamp_ready_low", n, BRUSH ? 3 : 0);
        disp_sel = 5'd31; #1; chk("row31", disp_bits, BRUSH ? 32'h0000_0003 : 32'h0000_0001);
        disp_sel = 5'd30; #1; chk("row30", disp_bits, BRUSH ? 32'h0000_0003 : 32'h0000_0000);
        disp_sel = 5'd29; #1; chk("row29", disp_bits, 32'h0000_0000);
        disp_hold = 1'b0;

        // clear with a pen waiting behind it
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        pen_x = 5'd9; pen_y = 5'd9; pen_ink = 1'b1; pen_valid = 1'b1;
        n = 0; seen = 1'b0;
        while (busy && n < 100) begin
            if (pen_ready) seen = 1'b1;
            n++; tick();
        end
        pen_valid = 1'b0;
        chk("clear_busy_cycles", n, 33);
        chk("pen_held_off", 32'(seen), 32'd0);
        chk("dirty_after_clear", 32'(dirty), 32'd0);
        count_ones(ones);
        chk("clear_all_zero", ones, 0);
        addr_hold = 1'b0;

        // diagonal
        for (int i = 0; i < 32; i++) pen(i, i, 1'b1);
        wait_idle();
        bad = 0;
        addr_hold = 1'b1;
        for (int a = 0; a < 1024; a++) begin
            addr_sel = 10'(a); #1;
            if (BRUSH) exp_px = ((a / 32 - a % 32) <= 2 && (a % 32 - a / 32) <= 2);
            else       exp_px = (a % 33 == 0);
            if (read_data !== exp_px) bad++;
        end
        chk("diag_sweep_mismatches", bad, 0);

        // lock holds off both the clear and the pen
        lock = 1'b1;
        pen_x = 5'd20; pen_y = 5'd3; pen_ink = 1'b1; pen_valid = 1'b1;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            addr_sel = 10'd116; #1;
            chk("locked_no_pen", 32'(read_data), 32'd0);
            addr_sel = 10'd165; #1;
            chk("locked_diag_kept", 32'(read_data), 32'd1);
            chk("locked_ready", 32'(pen_ready), 32'd0);
            tick();
        end
        lock = 1'b0;
        tick();
        chk("clear_started", 32'(busy), 32'd1);
        n = 0;
        while (!pen_ready && n < 100) begin n++; tick(); end
        chk("lock_clear_len", n, 32);
        tick();
        pen_valid = 1'b0;
        wait_idle();
        addr_sel = 10'd116; #1; chk("pen_after_clear", 32'(read_data), 32'd1);
        addr_sel = 10'd165; #1; chk("diag_cleared", 32'(read_data), 32'd0);
        addr_hold = 1'b0;

        // reset mid-clear at row 10
        pen(25, 25, 1'b1);
        wait_idle();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (11) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_dirty", 32'(dirty), 32'd0);
        count_ones(ones);
        chk("rst_mid_all_zero", ones, 0);
        addr_hold = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule

`default_nettype wire
